counter_load_rx: RTL and testbench
==================================

Name: counter_load_rx

Overview:
- Serial load-command receiver that sits directly upstream of the 8-bit loadable counter.
- Accepts a 3-wire, SPI-like frame on tile input pins: ser_cs_n, ser_clk, ser_data.
- Synchronises the three pins into clk, deserialises one byte MSB-first, and drives the counter's load_en/load_val pair with a single-cycle load strobe.
- Malformed frames are discarded and flagged; the counter is not disturbed.

Parameters:
- DATA_W, 8: payload width; must match the counter width.
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ser_cs_n  in  1  async frame select, active low; idle high.
- ser_clk  in  1  async serial clock; data sampled on its rising edge.
- ser_data  in  1  async serial data, MSB first.
- load_en  out  1  one-cycle strobe to the counter's load_en.
- load_val  out  DATA_W  byte to load; holds the last accepted value.
- frame_err  out  1  one-cycle strobe when a frame is discarded.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: load_en=0, load_val=0, frame_err=0, busy=0, state=IDLE, bit count=0.
  - Synchroniser chain and edge-history flop reset to 1 for cs_n, 0 for ser_clk and ser_data, so no edge is detected on reset release.
- Synchronisers: SYNC_STAGES flops per pin, then one history flop for edge detect.
  - cs_fall, cs_rise, and sclk_rise are single-cycle internal events.
- External timing requirement: ser_clk high and low phases each at least SYNC_STAGES+1 clk periods. Shorter phases are unsupported.
- Bit counter: width clog2(DATA_W+2); saturates at DATA_W+1.
- FSM transitions:
  - IDLE: cs_fall -> SHIFT, clear bit count. All other events ignored.
  - SHIFT: sclk_rise -> shift reg = {shift[DATA_W-2:0], data_sync}, count+1.
    - count reaches DATA_W -> ARMED.
    - cs_rise with count < DATA_W -> IDLE and pulse frame_err (short frame).
  - ARMED: cs_rise -> IDLE, load_val <= shift reg, pulse load_en.
    - sclk_rise -> ERROR (over-length frame).
  - ERROR: cs_rise -> IDLE, pulse frame_err. All clock edges ignored.
- Priority: if cs_rise and sclk_rise occur in the same cycle, cs_rise wins and the clock edge is discarded.
- Latency: load_en and frame_err are registered. They assert on the clk edge SYNC_STAGES+2 edges after the first edge that samples ser_cs_n high; with defaults, 4 edges. Each is high for exactly one cycle.
- load_val changes only together with load_en; otherwise it holds.
- load_en and frame_err are never high in the same cycle.
- Back-to-back frames: a new cs_fall may follow cs_rise after one idle cycle; frames are handled independently.
- Reset mid-frame: FSM returns to IDLE. The remainder of that frame is ignored because a fresh cs_fall is required; no load, no error.
- A cs_fall while not in IDLE (glitch) is ignored.

Optional Feature:
- Macro: COUNTER_LOAD_PARITY_EN.
- Defined:
  - Frame is DATA_W+1 bits; the last bit is even parity over the payload.
  - ARMED is reached after DATA_W+1 bits.
  - On cs_rise, a parity mismatch pulses frame_err instead of load_en, and load_val is unchanged.
- Undefined: frame is exactly DATA_W bits with no parity logic; a 9th bit is an over-length error.

Decomposition:
- counter_pkg (shared package):
  - DATA_W default constant.
  - rx_state_t enum: IDLE, SHIFT, ARMED, ERROR.
  - Frame-length constant, conditioned on COUNTER_LOAD_PARITY_EN.
- sync_edge sub-module: SYNC_STAGES synchroniser plus history flop, with outputs level, rise, fall and a reset-value parameter. Instantiated three times.
- FSM, shift register and bit counter live in counter_load_rx.

Test Plan:
- Reset release with ser_cs_n=1 and ser_clk=0 -> no load_en, no frame_err, busy=0, load_val=0x00.
- Frame 0xA5, MSB first, 8 clocks, then cs_n high -> load_en pulses 1 cycle, 4 clk edges after cs_n rise; load_val=0xA5 and holds.
- Short frame of 5 bits then cs_n high -> frame_err pulses once, load_en stays 0, load_val keeps its previous value 0xA5.
- Over-length frame of 9 clocks (parity undefined) -> frame_err on cs_n rise, no load; then a valid 0x3C frame -> load_val=0x3C.
- rst_n pulsed low after bit 3 of a frame -> outputs reset; remaining 5 bits and the cs_n rise produce no load_en and no frame_err.
- COUNTER_LOAD_PARITY_EN defined: 0x0F+parity 0 -> load_val=0x0F; 0x0F+parity 1 -> frame_err, load_val stays 0x0F.

Source files
------------

// File: rtl/counter_load_rx_pkg.sv
// Shared definitions for the serial load-command receiver.
// Optional feature macro: COUNTER_LOAD_PARITY_EN (appends an even-parity bit to each frame).
package counter_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ARMED = 2'd2,
        ERROR = 2'd3
    } rx_state_t;

`ifdef COUNTER_LOAD_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN_DEF = DATA_W_DEF + PARITY_BITS;

    // XOR-reduce of a zero-extended vector: 0 means an even number of ones.
    function automatic logic parity_of(input logic [31:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/counter_load_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history
// flop for edge detection. Edge events are registered single-cycle pulses.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_rise;
    logic                   r_fall;

    // Shift the pin through the synchroniser and register edge events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_hist;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/counter_load_rx.sv
// Serial load-command receiver feeding the loadable counter.
// Deserialises one MSB-first frame per ser_cs_n assertion and issues a
// single-cycle load strobe; malformed frames raise a frame_err strobe.
// Optional feature macro: COUNTER_LOAD_PARITY_EN (frame carries a trailing even-parity bit).
module counter_load_rx
    import counter_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_cs_n,
    input  logic              ser_clk,
    input  logic              ser_data,
    output logic              load_en,
    output logic [DATA_W-1:0] load_val,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_LEN = DATA_W + PARITY_BITS;
    localparam int CNT_W     = $clog2(DATA_W + 2);
    localparam int FILL_W    = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

    // Synchronised pin levels and edge events.
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_clk_level, w_sclk_rise, w_clk_fall;
    logic w_data_level, w_data_rise, w_data_fall;
    logic w_unused;

    // Registered state.
    rx_state_t             r_state;
    logic [CNT_W-1:0]      r_count;
    logic [FRAME_LEN-1:0]  r_shift;
    logic [DATA_W-1:0]     r_load_val;
    logic                  r_load_en;
    logic                  r_frame_err;
    logic                  r_busy;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_cs_armed;

    // Next-state values.
    rx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [FRAME_LEN-1:0]  w_shift_nxt;
    logic [DATA_W-1:0]     w_load_val_nxt;
    logic                  w_load_en_nxt;
    logic                  w_frame_err_nxt;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (ser_cs_n),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (ser_clk),
        .o_level (w_clk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_clk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (ser_data),
        .o_level (w_data_level),
        .o_rise  (w_data_rise),
        .o_fall  (w_data_fall)
    );

    assign w_unused = ^{w_clk_level, w_clk_fall, w_data_rise, w_data_fall};

    // Track synchroniser fill after reset; a frame may only start once cs_n
    // has genuinely been seen high, so a frame cut by reset is not resumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill     <= {FILL_W{1'b0}};
            r_cs_armed <= 1'b0;
        end else begin
            r_fill     <= (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
            r_cs_armed <= r_cs_armed | ((r_fill == FILL_MAX) & w_cs_level);
        end
    end

    // FSM next-state, shift, count and output-strobe decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_shift_nxt     = r_shift;
        w_load_val_nxt  = r_load_val;
        w_load_en_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall && r_cs_armed) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    // Any cs rise before the full frame is a short frame.
                    w_state_nxt     = IDLE;
                    w_frame_err_nxt = 1'b1;
                end else if (w_sclk_rise) begin
                    w_shift_nxt = {r_shift[FRAME_LEN-2:0], w_data_level};
                    w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
                    if (r_count == CNT_LAST) begin
                        w_state_nxt = ARMED;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            ARMED: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
`ifdef COUNTER_LOAD_PARITY_EN
                    if (parity_of(32'(r_shift)) == 1'b0) begin
                        w_load_val_nxt = r_shift[FRAME_LEN-1:1];
                        w_load_en_nxt  = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
`else
                    w_load_val_nxt = r_shift;
                    w_load_en_nxt  = 1'b1;
`endif
                end else if (w_sclk_rise) begin
                    w_state_nxt = ERROR;
                end else begin
                    w_state_nxt = ARMED;
                end
            end
            ERROR: begin
                if (w_cs_rise) begin
                    w_state_nxt     = IDLE;
                    w_frame_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = ERROR;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register FSM state, datapath and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= {CNT_W{1'b0}};
            r_shift     <= {FRAME_LEN{1'b0}};
            r_load_val  <= {DATA_W{1'b0}};
            r_load_en   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_shift     <= w_shift_nxt;
            r_load_val  <= w_load_val_nxt;
            r_load_en   <= w_load_en_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign load_en   = r_load_en;
    assign load_val  = r_load_val;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_counter_load_rx.sv
// Directed self-checking bench for counter_load_rx.
// Honours COUNTER_LOAD_PARITY_EN when defined.
module tb_counter_load_rx;

    localparam int PH = 4;

    logic       clk;
    logic       rst_n;
    logic       ser_cs_n;
    logic       ser_clk;
    logic       ser_data;
    logic       load_en;
    logic [7:0] load_val;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_both   = 0;

    int loads, errs, lat_load, lat_err;

    counter_load_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_cs_n  (ser_cs_n),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .load_en   (load_en),
        .load_val  (load_val),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ser_data = b;
        tick(PH);
        ser_clk = 1'b1;
        tick(PH);
        ser_clk = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_valid(input logic [7:0] v);
        send_word({8'h00, v}, 8);
`ifdef COUNTER_LOAD_PARITY_EN
        send_bit(^v);
`endif
    endtask

    task automatic start_frame();
        ser_cs_n = 1'b0;
        tick(PH);
    endtask

    // Raise cs_n and observe the strobes for a bounded window.
    task automatic end_frame(output int o_loads, output int o_errs, output int o_lat_load, output int o_lat_err);
        o_loads = 0; o_errs = 0; o_lat_load = -1; o_lat_err = -1;
        tick(PH);
        ser_cs_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (load_en === 1'b1) begin
                o_loads++;
                if (o_lat_load < 0) o_lat_load = k;
            end
            if (frame_err === 1'b1) begin
                o_errs++;
                if (o_lat_err < 0) o_lat_err = k;
            end
            if (load_en === 1'b1 && frame_err === 1'b1) n_both++;
        end
        tick(4);
    endtask

    initial begin
        rst_n = 1'b0; ser_cs_n = 1'b1; ser_clk = 1'b0; ser_data = 1'b0;
        tick(3);
        check_val("rst_load_en",   {31'd0, load_en},   32'd0);
        check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_val("rst_busy",      {31'd0, busy},      32'd0);
        check_val("rst_load_val",  {24'd0, load_val},  32'h00);
        rst_n = 1'b1;
        loads = 0; errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (load_en === 1'b1) loads++;
            if (frame_err === 1'b1 || busy === 1'b1) errs++;
        end
        check_val("rel_no_activity", loads + errs, 32'd0);
        tick(2);

        // Valid frame 0xA5.
        start_frame();
        check_val("a5_busy_mid", {31'd0, busy}, 32'd1);
        send_valid(8'hA5);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("a5_loads",   loads,    32'd1);
        check_val("a5_latency", lat_load, 32'd4);
        check_val("a5_errs",    errs,     32'd0);
        check_val("a5_val",     {24'd0, load_val}, 32'hA5);
        check_val("a5_busy_end", {31'd0, busy}, 32'd0);
        tick(10);
        check_val("a5_hold", {24'd0, load_val}, 32'hA5);

        // Short frame of 5 bits.
        start_frame();
        send_word(16'h0016, 5);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("short_errs",    errs,    32'd1);
        check_val("short_err_lat", lat_err, 32'd4);
        check_val("short_loads",   loads,   32'd0);
        check_val("short_val",     {24'd0, load_val}, 32'hA5);

        // Over-length frame: one bit beyond the full frame.
        start_frame();
`ifdef COUNTER_LOAD_PARITY_EN
        send_word(16'h0155, 10);
`else
        send_word(16'h0155, 9);
`endif
        end_frame(loads, errs, lat_load, lat_err);
        check_val("over_errs",  errs,  32'd1);
        check_val("over_loads", loads, 32'd0);
        check_val("over_val",   {24'd0, load_val}, 32'hA5);

        // Valid 0x3C after the error.
        start_frame();
        send_valid(8'h3C);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("3c_loads", loads, 32'd1);
        check_val("3c_errs",  errs,  32'd0);
        check_val("3c_val",   {24'd0, load_val}, 32'h3C);

        // Reset in the middle of a frame.
        start_frame();
        send_word(16'h0005, 3);
        rst_n = 1'b0;
        tick(1);
        check_val("mid_rst_val",  {24'd0, load_val}, 32'h00);
        check_val("mid_rst_busy", {31'd0, busy},     32'd0);
        check_val("mid_rst_en",   {31'd0, load_en},  32'd0);
        tick(2);
        rst_n = 1'b1;
        send_word(16'h0015, 5);
        check_val("mid_rst_busy_after", {31'd0, busy}, 32'd0);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("mid_rst_loads", loads, 32'd0);
        check_val("mid_rst_errs",  errs,  32'd0);
        check_val("mid_rst_val2",  {24'd0, load_val}, 32'h00);

        // Recovery with a fresh frame.
        start_frame();
        send_valid(8'h5A);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("5a_loads", loads, 32'd1);
        check_val("5a_val",   {24'd0, load_val}, 32'h5A);

`ifdef COUNTER_LOAD_PARITY_EN
        // Good parity: 0x0F has four ones, parity bit 0.
        start_frame();
        send_word(16'h0F, 8);
        send_bit(1'b0);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("par_ok_loads", loads, 32'd1);
        check_val("par_ok_errs",  errs,  32'd0);
        check_val("par_ok_val",   {24'd0, load_val}, 32'h0F);

        // Bad parity bit.
        start_frame();
        send_word(16'h0F, 8);
        send_bit(1'b1);
        end_frame(loads, errs, lat_load, lat_err);
        check_val("par_bad_errs",  errs,  32'd1);
        check_val("par_bad_loads", loads, 32'd0);
        check_val("par_bad_val",   {24'd0, load_val}, 32'h0F);
`endif

        check_val("strobes_exclusive", n_both, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
